alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
- Shares one combinational ALU datapath (ALUop encoding: AND/OR/ADD/SUB) between two requesters.
- Port A is the execute stage. Port B is a secondary requester, such as branch-target or address generation.
- Uses a valid/ready request handshake per port, round-robin arbitration, and a registered per-port response slot with backpressure.
- Sits between the issue logic and the ALU and owns the only ALU instance in the execute cluster.

Parameters:
- DATA_W, 32, operand/result width.
- OP_W, 4, ALUop width.
- CNT_W, 16, width of the saturating conflict counter.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- a_req_valid  in  1  port A request valid.
- a_req_ready  out  1  port A request accepted this cycle.
- a_req_op  in  OP_W  port A ALUop.
- a_req_op1  in  DATA_W  port A operand 1.
- a_req_op2  in  DATA_W  port A operand 2.
- a_rsp_valid  out  1  port A result valid.
- a_rsp_ready  in  1  port A consumer ready.
- a_rsp_result  out  DATA_W  port A result.
- a_rsp_err  out  1  port A op was not a supported ALUop.
- b_*  (same nine signals as port A, for port B).
- conflict_cnt  out  CNT_W  count of cycles where both ports were eligible.

Behaviour:
- Supported ops and results:
  - AND=4'b0000: op1&op2.
  - OR=4'b0001: op1|op2.
  - ADD=4'b0010: op1+op2, mod 2^DATA_W, carry dropped.
  - SUB=4'b0110: op1-op2, mod 2^DATA_W.
  - Any other op: result 0, rsp_err=1. The result never holds a stale value.
- Slot free: port X's response slot is free when x_rsp_valid=0, or when x_rsp_valid=1 and x_rsp_ready=1 in the same cycle (drain and refill in one cycle is allowed).
- Eligible: port X is eligible when x_req_valid=1 and its slot is free.
- Arbitration:
  - Only one grant per cycle.
  - Only A eligible: grant A. Only B eligible: grant B.
  - Both eligible: grant the port that is not last_grant.
  - last_grant updates only on a grant. Reset value of last_grant is B, so A wins the first conflict.
- Handshake:
  - x_req_ready is combinational: x_req_ready = grant_x. It may depend on x_req_valid.
  - The transfer occurs when valid and ready are both high.
  - A requester must hold op, op1 and op2 stable while valid=1 and ready=0.
  - Withdrawing an unaccepted request is legal, and nothing is recorded for it.
- Latency:
  - The ALU evaluates the granted operands combinationally in the accept cycle.
  - result/err are registered into the granted port's slot at that edge.
  - x_rsp_valid=1 from the next cycle, so latency is 1 cycle.
  - Throughput is one op per cycle in aggregate.
- Response hold: while x_rsp_valid=1 and x_rsp_ready=0, x_rsp_result and x_rsp_err hold stable and port X is not eligible.
- Response clear: x_rsp_valid drops the cycle after a drain unless refilled at the same edge.
- Independence: each port's response slot is independent. A stalled consumer on A never blocks B.
- Conflict counter:
  - conflict_cnt increments by 1 in each cycle where both ports are eligible.
  - It saturates at all-ones and does not wrap.
- Reset values: all req_ready=0 and all rsp_valid=0 (combinationally 0 while rst=1). rsp_result=0, rsp_err=0, conflict_cnt=0, last_grant=B.
- Reset mid-operation: in-flight results are discarded and never presented. Requests held across reset are re-arbitrated normally from the first cycle after rst deasserts.
- No state machine beyond last_grant and two 1-entry slots. There are no multi-cycle ops, so no busy state.

Decomposition:
- Shared package alu_pkg:
  - ALUop localparams AND_OP, OR_OP, ADD_OP, SUB_OP.
  - An is_legal_op function.
  - PORT_A/PORT_B grant encoding constants.
- Sub-module alu_resp_slot: a 1-entry valid/ready output register holding result+err. Instantiated twice.
- The ALU datapath is instantiated once inside the top.

Test Plan:
- Single ADD: A sends op=0010, op1=5, op2=3, B idle.
  - a_req_ready=1 in the same cycle.
  - Next cycle: a_rsp_valid=1, result=8, err=0.
  - conflict_cnt stays 0.
- Wrap: B sends SUB with op1=3, op2=5 -> result 32'hFFFFFFFE. A sends ADD with 32'hFFFFFFFF+1 -> result 0.
- Simultaneous requests: A=OR(0xF0,0x0F) and B=AND(0xFF,0x3C) held from cycle 0, both rsp_ready=1.
  - Cycle 0: A granted. Cycle 1: B granted.
  - a_rsp=0xFF, b_rsp=0x3C.
  - conflict_cnt=1.
  - Three back-to-back conflicts continue alternating A, B, A.
- Backpressure: a_rsp_ready=0 with A's result 8 pending, then a new A request.
  - a_req_ready=0, result holds 8, B keeps being granted.
  - Raising a_rsp_ready accepts the new A request in that same cycle.
- Illegal op: A sends op=4'b1111 -> next cycle result=0, err=1. A following legal ADD clears err.
- Reset mid-operation: assert rst the cycle after an accept.
  - No rsp_valid appears, conflict_cnt=0, last_grant=B.
  - On a simultaneous A/B request after reset, A wins.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALUop encodings, legality check and grant encoding for the shared ALU cluster.
package alu_pkg;

    // Widest ALUop the legality helper inspects; callers zero-extend into it.
    localparam int MAX_OP_W = 8;

    localparam logic [3:0] AND_OP = 4'b0000;
    localparam logic [3:0] OR_OP  = 4'b0001;
    localparam logic [3:0] ADD_OP = 4'b0010;
    localparam logic [3:0] SUB_OP = 4'b0110;

    // Grant / last-grant encoding.
    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_e;

    function automatic logic is_legal_op(input logic [MAX_OP_W-1:0] op);
        return (op == MAX_OP_W'(AND_OP)) || (op == MAX_OP_W'(OR_OP)) ||
               (op == MAX_OP_W'(ADD_OP)) || (op == MAX_OP_W'(SUB_OP));
    endfunction

endpackage

// File: rtl/alu_resp_slot.sv
// One-entry valid/ready response register holding an ALU result and its error flag.
module alu_resp_slot #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [DATA_W-1:0] result_i,
    input  logic              err_i,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] result_o,
    output logic              err_o
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              err_q, err_d;

    // Fill on load (load wins over a same-cycle drain), clear on drain, otherwise hold.
    always_comb begin
        valid_d  = valid_q;
        result_d = result_q;
        err_d    = err_q;
        if (load_i) begin
            valid_d  = 1'b1;
            result_d = result_i;
            err_d    = err_i;
        end else if (ready_i) begin
            valid_d  = 1'b0;
        end
    end

    // Slot register; reset discards any in-flight result.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    // Valid is forced low while reset is held so nothing is presented during reset.
    assign valid_o  = valid_q & ~rst;
    assign result_o = result_q;
    assign err_o    = err_q;

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between two valid/ready requesters.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OP_W   = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req_valid,
    output logic              a_req_ready,
    input  logic [OP_W-1:0]   a_req_op,
    input  logic [DATA_W-1:0] a_req_op1,
    input  logic [DATA_W-1:0] a_req_op2,
    output logic              a_rsp_valid,
    input  logic              a_rsp_ready,
    output logic [DATA_W-1:0] a_rsp_result,
    output logic              a_rsp_err,
    input  logic              b_req_valid,
    output logic              b_req_ready,
    input  logic [OP_W-1:0]   b_req_op,
    input  logic [DATA_W-1:0] b_req_op1,
    input  logic [DATA_W-1:0] b_req_op2,
    output logic              b_rsp_valid,
    input  logic              b_rsp_ready,
    output logic [DATA_W-1:0] b_rsp_result,
    output logic              b_rsp_err,
    output logic [CNT_W-1:0]  conflict_cnt
);

    port_e             last_grant_q, last_grant_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              elig_a, elig_b, gnt_a, gnt_b;
    logic [OP_W-1:0]   sel_op;
    logic [DATA_W-1:0] sel_op1, sel_op2, alu_res;
    logic              alu_err;

    // Eligibility and round-robin grant; a slot being drained this cycle counts as free.
    always_comb begin
        elig_a = ~rst & a_req_valid & (~a_rsp_valid | a_rsp_ready);
        elig_b = ~rst & b_req_valid & (~b_rsp_valid | b_rsp_ready);
        gnt_a  = elig_a & (~elig_b | (last_grant_q == PORT_B));
        gnt_b  = elig_b & ~gnt_a;
    end

    assign a_req_ready = gnt_a;
    assign b_req_ready = gnt_b;

    // Single shared ALU fed by the granted port; unsupported ops yield 0 with err set.
    always_comb begin
        sel_op  = gnt_b ? b_req_op  : a_req_op;
        sel_op1 = gnt_b ? b_req_op1 : a_req_op1;
        sel_op2 = gnt_b ? b_req_op2 : a_req_op2;
        alu_res = '0;
        alu_err = ~is_legal_op(MAX_OP_W'(sel_op));
        case (sel_op)
            OP_W'(AND_OP): alu_res = sel_op1 & sel_op2;
            OP_W'(OR_OP):  alu_res = sel_op1 | sel_op2;
            OP_W'(ADD_OP): alu_res = sel_op1 + sel_op2;
            OP_W'(SUB_OP): alu_res = sel_op1 - sel_op2;
            default:       alu_res = '0;
        endcase
    end

    // Next state for the grant history and the saturating conflict counter.
    always_comb begin
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        if (gnt_a) last_grant_d = PORT_A;
        else if (gnt_b) last_grant_d = PORT_B;
        if (elig_a && elig_b && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
    end

    // Arbiter state; reset favours A on the first conflict.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= PORT_B;
            cnt_q        <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
        end
    end

    assign conflict_cnt = cnt_q;

    alu_resp_slot #(.DATA_W(DATA_W)) u_slot_a (
        .clk      (clk),
        .rst      (rst),
        .load_i   (gnt_a),
        .result_i (alu_res),
        .err_i    (alu_err),
        .ready_i  (a_rsp_ready),
        .valid_o  (a_rsp_valid),
        .result_o (a_rsp_result),
        .err_o    (a_rsp_err)
    );

    alu_resp_slot #(.DATA_W(DATA_W)) u_slot_b (
        .clk      (clk),
        .rst      (rst),
        .load_i   (gnt_b),
        .result_i (alu_res),
        .err_i    (alu_err),
        .ready_i  (b_rsp_ready),
        .valid_o  (b_rsp_valid),
        .result_o (b_rsp_result),
        .err_o    (b_rsp_err)
    );

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with hand-computed expectations.
module tb_alu_share_arbiter;

    localparam int DATA_W = 32;
    localparam int OP_W   = 4;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              a_req_valid, a_req_ready, a_rsp_valid, a_rsp_ready, a_rsp_err;
    logic              b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready, b_rsp_err;
    logic [OP_W-1:0]   a_req_op, b_req_op;
    logic [DATA_W-1:0] a_req_op1, a_req_op2, b_req_op1, b_req_op2;
    logic [DATA_W-1:0] a_rsp_result, b_rsp_result;
    logic [CNT_W-1:0]  conflict_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.DATA_W(DATA_W), .OP_W(OP_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .a_req_valid  (a_req_valid),
        .a_req_ready  (a_req_ready),
        .a_req_op     (a_req_op),
        .a_req_op1    (a_req_op1),
        .a_req_op2    (a_req_op2),
        .a_rsp_valid  (a_rsp_valid),
        .a_rsp_ready  (a_rsp_ready),
        .a_rsp_result (a_rsp_result),
        .a_rsp_err    (a_rsp_err),
        .b_req_valid  (b_req_valid),
        .b_req_ready  (b_req_ready),
        .b_req_op     (b_req_op),
        .b_req_op1    (b_req_op1),
        .b_req_op2    (b_req_op2),
        .b_rsp_valid  (b_rsp_valid),
        .b_rsp_ready  (b_rsp_ready),
        .b_rsp_result (b_rsp_result),
        .b_rsp_err    (b_rsp_err),
        .conflict_cnt (conflict_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge, where inputs are changed.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic v, input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        a_req_valid = v; a_req_op = op; a_req_op1 = x; a_req_op2 = y;
    endtask

    task automatic drive_b(input logic v, input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        b_req_valid = v; b_req_op = op; b_req_op1 = x; b_req_op2 = y;
    endtask

    initial begin
        rst = 1'b1;
        a_rsp_ready = 1'b1;
        b_rsp_ready = 1'b1;
        drive_a(1'b1, 4'b0010, 32'd1, 32'd1);
        drive_b(1'b1, 4'b0010, 32'd1, 32'd1);
        step();
        step();
        @(negedge clk);
        check("rst_a_req_ready", a_req_ready, 0);
        check("rst_b_req_ready", b_req_ready, 0);
        check("rst_a_rsp_valid", a_rsp_valid, 0);
        check("rst_b_rsp_valid", b_rsp_valid, 0);
        check("rst_a_result", a_rsp_result, 0);
        check("rst_a_err", a_rsp_err, 0);
        check("rst_cnt", conflict_cnt, 0);
        step();
        rst = 1'b0;
        drive_a(1'b0, 4'b0000, 32'd0, 32'd0);
        drive_b(1'b0, 4'b0000, 32'd0, 32'd0);
        step();

        // Single ADD on A
        drive_a(1'b1, 4'b0010, 32'd5, 32'd3);
        @(negedge clk);
        check("add_a_ready", a_req_ready, 1);
        check("add_b_ready", b_req_ready, 0);
        step();
        drive_a(1'b0, 4'b0000, 32'd0, 32'd0);
        @(negedge clk);
        check("add_rsp_valid", a_rsp_valid, 1);
        check("add_result", a_rsp_result, 8);
        check("add_err", a_rsp_err, 0);
        check("add_cnt", conflict_cnt, 0);

        // Wrap: A ADD then B SUB, leaving last_grant=B
        step();
        check("add_drained", a_rsp_valid, 0);
        drive_a(1'b1, 4'b0010, 32'hFFFF_FFFF, 32'd1);
        step();
        drive_a(1'b0, 4'b0000, 32'd0, 32'd0);
        drive_b(1'b1, 4'b0110, 32'd3, 32'd5);
        @(negedge clk);
        check("wrap_add_result", a_rsp_result, 0);
        check("wrap_add_valid", a_rsp_valid, 1);
        check("wrap_b_ready", b_req_ready, 1);
        step();
        drive_b(1'b0, 4'b0000, 32'd0, 32'd0);
        @(negedge clk);
        check("wrap_sub_result", b_rsp_result, 32'hFFFF_FFFE);
        check("wrap_sub_valid", b_rsp_valid, 1);
        check("wrap_cnt", conflict_cnt, 0);
        step();

        // Simultaneous requests
        drive_a(1'b1, 4'b0001, 32'hF0, 32'h0F);
        drive_b(1'b1, 4'b0000, 32'hFF, 32'h3C);
        @(negedge clk);
        check("sim0_a_ready", a_req_ready, 1);
        check("sim0_b_ready", b_req_ready, 0);
        step();
        drive_a(1'b0, 4'b0000, 32'd0, 32'd0);
        @(negedge clk);
        check("sim1_b_ready", b_req_ready, 1);
        check("sim1_a_result", a_rsp_result, 32'hFF);
        check("sim1_cnt", conflict_cnt, 1);
        step();
        drive_b(1'b0, 4'b0000, 32'd0, 32'd0);
        @(negedge clk);
        check("sim2_b_result", b_rsp_result, 32'h3C);
        check("sim2_b_valid", b_rsp_valid, 1);
        step();

        // Three back-to-back conflicts: A, B, A
        drive_a(1'b1, 4'b0010, 32'd1, 32'd2);
        drive_b(1'b1, 4'b0110, 32'd10, 32'd4);
        @(negedge clk);
        check("rr0_a_ready", a_req_ready, 1);
        check("rr0_b_ready", b_req_ready, 0);
        step();
        @(negedge clk);
        check("rr1_a_ready", a_req_ready, 0);
        check("rr1_b_ready", b_req_ready, 1);
        check("rr1_a_result", a_rsp_result, 3);
        step();
        @(negedge clk);
        check("rr2_a_ready", a_req_ready, 1);
        check("rr2_b_ready", b_req_ready, 0);
        check("rr2_b_result", b_rsp_result, 6);
        step();
        drive_a(1'b0, 4'b0000, 32'd0, 32'd0);
        drive_b(1'b0, 4'b0000, 32'd0, 32'd0);
        @(negedge clk);
        check("rr_cnt", conflict_cnt, 4);
        step();

        // Backpressure on A's response slot
        a_rsp_ready = 1'b0;
        drive_a(1'b1, 4'b0010, 32'd5, 32'd3);
        @(negedge clk);
        check("bp_first_a_ready", a_req_ready, 1);
        step();
        drive_a(1'b1, 4'b0000, 32'hFF, 32'h0F);
        drive_b(1'b1, 4'b0110, 32'd10, 32'd4);
        @(negedge clk);
        check("bp0_a_ready", a_req_ready, 0);
        check("bp0_b_ready", b_req_ready, 1);
        check("bp0_a_result", a_rsp_result, 8);
        check("bp0_a_valid", a_rsp_valid, 1);
        step();
        @(negedge clk);
        check("bp1_a_ready", a_req_ready, 0);
        check("bp1_b_ready", b_req_ready, 1);
        check("bp1_a_result", a_rsp_result, 8);
        check("bp1_b_result", b_rsp_result, 6);
        step();
        drive_b(1'b0, 4'b0000, 32'd0, 32'd0);
        a_rsp_ready = 1'b1;
        @(negedge clk);
        check("bp2_a_ready", a_req_ready, 1);
        step();
        drive_a(1'b0, 4'b0000, 32'd0, 32'd0);
        @(negedge clk);
        check("bp3_a_result", a_rsp_result, 32'h0F);
        check("bp3_a_valid", a_rsp_valid, 1);
        check("bp_cnt", conflict_cnt, 4);
        step();

        // Illegal op followed by a legal ADD
        drive_a(1'b1, 4'b1111, 32'd5, 32'd3);
        step();
        drive_a(1'b1, 4'b0010, 32'd5, 32'd3);
        @(negedge clk);
        check("ill_valid", a_rsp_valid, 1);
        check("ill_result", a_rsp_result, 0);
        check("ill_err", a_rsp_err, 1);
        check("ill_next_ready", a_req_ready, 1);
        step();
        drive_a(1'b0, 4'b0000, 32'd0, 32'd0);
        @(negedge clk);
        check("legal_result", a_rsp_result, 8);
        check("legal_err", a_rsp_err, 0);
        step();

        // Reset the cycle after an accept (last_grant is A here)
        drive_a(1'b1, 4'b0010, 32'd7, 32'd1);
        step();
        drive_a(1'b0, 4'b0000, 32'd0, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_a_valid", a_rsp_valid, 0);
        step();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_a_valid", a_rsp_valid, 0);
        check("post_rst_a_result", a_rsp_result, 0);
        check("post_rst_cnt", conflict_cnt, 0);
        step();
        drive_a(1'b1, 4'b0001, 32'd1, 32'd2);
        drive_b(1'b1, 4'b0001, 32'd4, 32'd8);
        @(negedge clk);
        check("post_rst_a_wins", a_req_ready, 1);
        check("post_rst_b_waits", b_req_ready, 0);

        // Hold both requesters for 20 cycles: counter must stop at all-ones
        for (int i = 0; i < 20; i++) step();
        @(negedge clk);
        check("cnt_saturated", conflict_cnt, 4'hF);
        step();
        @(negedge clk);
        check("cnt_no_wrap", conflict_cnt, 4'hF);
        drive_a(1'b0, 4'b0000, 32'd0, 32'd0);
        drive_b(1'b0, 4'b0000, 32'd0, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
